// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA raster generator.
//   - Default 640x480@60 timing, plus the derived totals and sync windows
//   - Colour field widths and the packed 8-bit rgb_t pixel type
//   - BG_COLOR: the colour shown in the visible area when nothing is drawn
package vga_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 2;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  localparam int COORD_W = 10;
  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 2;

  typedef struct packed {
    logic [RED_W-1:0]   red;
    logic [GREEN_W-1:0] green;
    logic [BLUE_W-1:0]  blue;
  } rgb_t;

  localparam rgb_t BG_COLOR = 8'h00;

endpackage

// File: rtl/vga_counter.sv
// vga_counter: modulo-N counter with enable, used for both raster axes.
//   clk_i, reset_i : clock and synchronous active-high reset
//   en_i           : advance the count on this edge
//   count_o        : current count, 0..N-1
//   next_o         : value count_o will take on the coming edge
//   wrap_o         : count_o is at N-1 (the next enabled edge returns to 0)
module vga_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         atLast;

  assign atLast = (count_q == LAST);

  // Next count: hold unless enabled, then step or fold back to zero at the end of range.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      if (atLast) begin
        count_d = '0;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;
  assign wrap_o  = atLast;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing plus the final registered colour stage.
//   clk, reset                     : clock, synchronous active-high reset
//   ball_on / ball_{red,green,blue}: ball request and colour for the current pixel
//   paddle_on / paddle_{...}       : paddle request and colour for the current pixel
//   x, y, pixel_tick, video_on,
//   endofframe                     : stage-0 raster state
//   hsync, vsync, red, green, blue : stage-1 outputs, one clk behind stage 0
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ball_on,
  input  logic [RED_W-1:0]   ball_red,
  input  logic [GREEN_W-1:0] ball_green,
  input  logic [BLUE_W-1:0]  ball_blue,
  input  logic               paddle_on,
  input  logic [RED_W-1:0]   paddle_red,
  input  logic [GREEN_W-1:0] paddle_green,
  input  logic [BLUE_W-1:0]  paddle_blue,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pixel_tick,
  output logic               video_on,
  output logic               endofframe,
  output logic               hsync,
  output logic               vsync,
  output logic [RED_W-1:0]   red,
  output logic [GREEN_W-1:0] green,
  output logic [BLUE_W-1:0]  blue
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COORD_W-1:0] H_DISP_C   = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_DISP_C   = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] H_SSTART_C = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] H_SEND_C   = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] V_SSTART_C = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] V_SEND_C   = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick_q, tick_d;
  logic               videoOn_q, videoOn_d;
  logic               eof_q, eof_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  rgb_t               rgb_q, rgb_d;

  logic [COORD_W-1:0] xNext;
  logic [COORD_W-1:0] yNext;
  logic               hWrap;
  logic               vWrap;
  logic               vEnable;

  // The line counter only moves on the pixel that finishes a line, so an x and
  // y wrap at the last pixel of the frame land on the same edge.
  assign vEnable = tick_q & hWrap;

  vga_counter #(.N(H_TOTAL), .W(COORD_W)) hCounter (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (tick_q),
    .count_o (x),
    .next_o  (xNext),
    .wrap_o  (hWrap)
  );

  vga_counter #(.N(V_TOTAL), .W(COORD_W)) vCounter (
    .clk_i   (clk),
    .reset_i (reset),
    .en_i    (vEnable),
    .count_o (y),
    .next_o  (yNext),
    .wrap_o  (vWrap)
  );

  // Stage 0: the tick is decoded from the next divider value so it is high in
  // the cycle where the divider sits at its last count. video_on/endofframe use
  // the counters' next values so they switch on the same edge as x/y.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
    tick_d    = (div_d == DIV_LAST);
    videoOn_d = (xNext < H_DISP_C) && (yNext < V_DISP_C);
    eof_d     = (yNext >= V_DISP_C);
  end

  // Stage 1: sync decode and colour mux both look at the current stage-0
  // coordinate, so syncs and colour stay aligned to each other.
  always_comb begin
    hsync_d = !((x >= H_SSTART_C) && (x <= H_SEND_C));
    vsync_d = !((y >= V_SSTART_C) && (y <= V_SEND_C));
    rgb_d   = BG_COLOR;
    if (!videoOn_q) begin
      rgb_d = '0;
    end else if (ball_on) begin
      rgb_d = {ball_red, ball_green, ball_blue};
    end else if (paddle_on) begin
      rgb_d = {paddle_red, paddle_green, paddle_blue};
    end
  end

  // All raster and output registers; reset puts the beam back at the top-left
  // without finishing the current line.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      tick_q    <= 1'b0;
      videoOn_q <= 1'b1;
      eof_q     <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= '0;
    end else begin
      div_q     <= div_d;
      tick_q    <= tick_d;
      videoOn_q <= videoOn_d;
      eof_q     <= eof_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
    end
  end

  assign pixel_tick = tick_q;
  assign video_on   = videoOn_q;
  assign endofframe = eof_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign red        = rgb_q.red;
  assign green      = rgb_q.green;
  assign blue       = rgb_q.blue;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: two instances sharing stimulus -- a shrunken raster
// (24x17 pixels total) that completes many frames, and the default 640x480
// raster for the first lines. Expected values are queued with the cycle they
// apply to; a monitor process compares them when that cycle comes round.
module tb_vga_sync_gen;

  localparam int S_HD = 16, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VD = 10, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VD + S_VF + S_VS + S_VB;

  localparam int SIG_X = 0, SIG_Y = 1, SIG_TICK = 2, SIG_VIDEO = 3;
  localparam int SIG_EOF = 4, SIG_HS = 5, SIG_VS = 6, SIG_RGB = 7;

  typedef struct {
    int    cyc;
    int    dut;
    int    sig;
    int    expVal;
    string name;
  } item_t;

  typedef struct {
    int         k;
    logic       bOn;
    logic       pOn;
    logic [7:0] bCol;
    logic [7:0] pCol;
    int         expS;
    int         expD;
  } colStep_t;

  logic clk = 1'b0;
  logic reset;
  logic ballOn, paddleOn;
  logic [2:0] ballRed, ballGreen, paddleRed, paddleGreen;
  logic [1:0] ballBlue, paddleBlue;

  logic [9:0] sX, sY, dX, dY;
  logic sTick, sVideo, sEof, sHsync, sVsync;
  logic dTick, dVideo, dEof, dHsync, dVsync;
  logic [2:0] sRed, sGreen, dRed, dGreen;
  logic [1:0] sBlue, dBlue;

  item_t sb[$];
  int absCyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;
  logic inReset = 1'b1;
  int sRises = 0;
  int dRises = 0;
  int sHsRuns = 0;

  always #5 clk = ~clk;

  // Edge counter and a record of whether the last edge was a reset edge.
  always @(posedge clk) begin
    absCyc  <= absCyc + 1;
    inReset <= reset;
  end

  vga_sync_gen #(
    .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
    .CLK_DIV(2)
  ) dutS (
    .clk(clk), .reset(reset),
    .ball_on(ballOn), .ball_red(ballRed), .ball_green(ballGreen), .ball_blue(ballBlue),
    .paddle_on(paddleOn), .paddle_red(paddleRed), .paddle_green(paddleGreen),
    .paddle_blue(paddleBlue),
    .x(sX), .y(sY), .pixel_tick(sTick), .video_on(sVideo), .endofframe(sEof),
    .hsync(sHsync), .vsync(sVsync), .red(sRed), .green(sGreen), .blue(sBlue)
  );

  vga_sync_gen dutD (
    .clk(clk), .reset(reset),
    .ball_on(ballOn), .ball_red(ballRed), .ball_green(ballGreen), .ball_blue(ballBlue),
    .paddle_on(paddleOn), .paddle_red(paddleRed), .paddle_green(paddleGreen),
    .paddle_blue(paddleBlue),
    .x(dX), .y(dY), .pixel_tick(dTick), .video_on(dVideo), .endofframe(dEof),
    .hsync(dHsync), .vsync(dVsync), .red(dRed), .green(dGreen), .blue(dBlue)
  );

  function automatic int getSig(input int dut, input int sig);
    if (dut == 0) begin
      case (sig)
        SIG_X:     return int'(sX);
        SIG_Y:     return int'(sY);
        SIG_TICK:  return int'(sTick);
        SIG_VIDEO: return int'(sVideo);
        SIG_EOF:   return int'(sEof);
        SIG_HS:    return int'(sHsync);
        SIG_VS:    return int'(sVsync);
        SIG_RGB:   return int'({sRed, sGreen, sBlue});
        default:   return -1;
      endcase
    end
    case (sig)
      SIG_X:     return int'(dX);
      SIG_Y:     return int'(dY);
      SIG_TICK:  return int'(dTick);
      SIG_VIDEO: return int'(dVideo);
      SIG_EOF:   return int'(dEof);
      SIG_HS:    return int'(dHsync);
      SIG_VS:    return int'(dVsync);
      SIG_RGB:   return int'({dRed, dGreen, dBlue});
      default:   return -1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int act, input int expVal);
    checks++;
    if (act != expVal) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expVal, absCyc);
    end
  endtask

  task automatic applyStimulus(input logic bOn, input logic pOn,
                               input logic [7:0] bCol, input logic [7:0] pCol);
    ballOn      = bOn;
    paddleOn    = pOn;
    ballRed     = bCol[7:5];
    ballGreen   = bCol[4:2];
    ballBlue    = bCol[1:0];
    paddleRed   = pCol[7:5];
    paddleGreen = pCol[4:2];
    paddleBlue  = pCol[1:0];
  endtask

  task automatic expectAt(input int c, input int dut, input int sig, input int expVal,
                          input string name);
    item_t it;
    it.cyc    = base + c;
    it.dut    = dut;
    it.sig    = sig;
    it.expVal = expVal;
    it.name   = $sformatf("%s_%s@%0d", (dut == 0) ? "S" : "D", name, c);
    sb.push_back(it);
  endtask

  task automatic expectResetState(input int c);
    for (int d = 0; d < 2; d++) begin
      expectAt(c, d, SIG_X, 0, "rstX");
      expectAt(c, d, SIG_Y, 0, "rstY");
      expectAt(c, d, SIG_TICK, 0, "rstTick");
      expectAt(c, d, SIG_VIDEO, 1, "rstVideo");
      expectAt(c, d, SIG_EOF, 0, "rstEof");
      expectAt(c, d, SIG_HS, 1, "rstHsync");
      expectAt(c, d, SIG_VS, 1, "rstVsync");
      expectAt(c, d, SIG_RGB, 0, "rstRgb");
    end
  endtask

  // Called at a falling edge; returns at the falling edge after relative edge c.
  task automatic waitRel(input int c);
    while (absCyc < base + c) @(negedge clk);
  endtask

  task automatic randomInputs();
    applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom), 8'($urandom));
  endtask

  // Monitor: compare every queued expectation whose cycle has arrived.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == absCyc) begin
          checkOutput(sb[i].name, getSig(sb[i].dut, sb[i].sig), sb[i].expVal);
          sb.delete(i);
        end else if (sb[i].cyc < absCyc) begin
          checks++;
          errors++;
          $display("[TB] FAIL %s: never sampled, due cycle %0d, now %0d",
                   sb[i].name, sb[i].cyc, absCyc);
          sb.delete(i);
        end
      end
    end
  end

  // Pulse-width and frame-marker measurements, restarted after every reset edge.
  initial begin
    int sHsRun, sVsRun, dHsRun, sLastRise;
    logic sPrevEof, dPrevEof;
    sHsRun = 0; sVsRun = 0; dHsRun = 0; sLastRise = -1;
    sPrevEof = 1'b0; dPrevEof = 1'b0;
    forever begin
      @(negedge clk);
      if (inReset) begin
        sHsRun = 0; sVsRun = 0; dHsRun = 0; sLastRise = -1;
        sPrevEof = 1'b0; dPrevEof = 1'b0;
      end else begin
        if (!sHsync) sHsRun++;
        else if (sHsRun != 0) begin
          checkOutput("S_hsyncLowClk", sHsRun, 2 * S_HS);
          sHsRuns++;
          sHsRun = 0;
        end
        if (!sVsync) sVsRun++;
        else if (sVsRun != 0) begin
          checkOutput("S_vsyncLowClk", sVsRun, 2 * S_VS * S_HT);
          sVsRun = 0;
        end
        if (!dHsync) dHsRun++;
        else if (dHsRun != 0) begin
          checkOutput("D_hsyncLowClk", dHsRun, 192);
          dHsRun = 0;
        end
        if (sEof && !sPrevEof) begin
          sRises++;
          checkOutput("S_eofRiseY", int'(sY), S_VD);
          if (sLastRise >= 0) checkOutput("S_eofPeriod", absCyc - sLastRise, 2 * S_HT * S_VT);
          sLastRise = absCyc;
        end
        if (dEof && !dPrevEof) dRises++;
        sPrevEof = sEof;
        dPrevEof = dEof;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus.
  initial begin
    colStep_t steps[$];
    steps.push_back('{4,    1'b1, 1'b1, 8'h1C, 8'h03, 'h1C, 'h1C});
    steps.push_back('{5,    1'b0, 1'b1, 8'h1C, 8'h03, 'h03, 'h03});
    steps.push_back('{6,    1'b0, 1'b0, 8'h1C, 8'h03, 'h00, 'h00});
    steps.push_back('{8,    1'b1, 1'b0, 8'hA9, 8'h03, 'hA9, 'hA9});
    steps.push_back('{9,    1'b0, 1'b0, 8'hA9, 8'h03, 'h00, 'h00});
    steps.push_back('{32,   1'b1, 1'b0, 8'hA9, 8'h03, 'h00, 'hA9});
    steps.push_back('{33,   1'b0, 1'b0, 8'hA9, 8'h03, 'h00, 'h00});
    steps.push_back('{1400, 1'b1, 1'b0, 8'h1C, 8'h03, 'h00, 'h00});
    steps.push_back('{1401, 1'b0, 1'b0, 8'h1C, 8'h03, 'h00, 'h00});

    // Reset for three edges with random colour requests.
    reset = 1'b1;
    randomInputs();
    base = 0;
    expectResetState(3);
    repeat (3) begin
      @(negedge clk);
      randomInputs();
    end

    // Release; relative cycle c counts edges from here.
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    base = absCyc;

    expectAt(1, 0, SIG_TICK, 1, "firstTick");
    expectAt(1, 0, SIG_X, 0, "xHold");
    expectAt(2, 0, SIG_TICK, 0, "tickLow");
    expectAt(2, 0, SIG_X, 1, "xStep1");
    expectAt(3, 0, SIG_X, 1, "xHold1");
    expectAt(4, 0, SIG_X, 2, "xStep2");
    expectAt(31, 0, SIG_VIDEO, 1, "videoLast");
    expectAt(32, 0, SIG_VIDEO, 0, "videoOff");
    expectAt(36, 0, SIG_HS, 1, "hsBefore");
    expectAt(37, 0, SIG_HS, 0, "hsStart");
    expectAt(42, 0, SIG_HS, 0, "hsEnd");
    expectAt(43, 0, SIG_HS, 1, "hsAfter");
    expectAt(479, 0, SIG_EOF, 0, "eofBefore");
    expectAt(479, 0, SIG_Y, 9, "yBeforeEof");
    expectAt(480, 0, SIG_EOF, 1, "eofRise");
    expectAt(480, 0, SIG_Y, 10, "yAtEof");
    expectAt(480, 0, SIG_VIDEO, 0, "videoVblank");
    expectAt(527, 0, SIG_X, 23, "lineEndX");
    expectAt(527, 0, SIG_Y, 10, "lineEndY");
    expectAt(528, 0, SIG_X, 0, "lineWrapX");
    expectAt(528, 0, SIG_Y, 11, "lineWrapY");
    expectAt(576, 0, SIG_VS, 1, "vsBefore");
    expectAt(577, 0, SIG_VS, 0, "vsStart");
    expectAt(672, 0, SIG_VS, 0, "vsEnd");
    expectAt(673, 0, SIG_VS, 1, "vsAfter");
    expectAt(815, 0, SIG_X, 23, "frameEndX");
    expectAt(815, 0, SIG_Y, 16, "frameEndY");
    expectAt(815, 0, SIG_EOF, 1, "frameEndEof");
    expectAt(816, 0, SIG_X, 0, "frameWrapX");
    expectAt(816, 0, SIG_Y, 0, "frameWrapY");
    expectAt(816, 0, SIG_EOF, 0, "frameWrapEof");
    expectAt(816, 0, SIG_VIDEO, 1, "frameWrapVideo");
    expectAt(18566, 0, SIG_X, 19, "preRstX");
    expectAt(18566, 0, SIG_Y, 12, "preRstY");
    expectAt(18566, 0, SIG_EOF, 1, "preRstEof");
    expectAt(18566, 0, SIG_HS, 0, "preRstHs");
    expectAt(18566, 0, SIG_VS, 0, "preRstVs");

    expectAt(1, 1, SIG_TICK, 1, "firstTick");
    expectAt(1279, 1, SIG_VIDEO, 1, "videoLast");
    expectAt(1280, 1, SIG_VIDEO, 0, "videoOff");
    expectAt(1312, 1, SIG_HS, 1, "hsBefore");
    expectAt(1313, 1, SIG_HS, 0, "hsStart");
    expectAt(1504, 1, SIG_HS, 0, "hsEnd");
    expectAt(1505, 1, SIG_HS, 1, "hsAfter");
    expectAt(17599, 1, SIG_X, 799, "lineEndX");
    expectAt(17599, 1, SIG_Y, 10, "lineEndY");
    expectAt(17600, 1, SIG_X, 0, "lineWrapX");
    expectAt(17600, 1, SIG_Y, 11, "lineWrapY");
    expectAt(17600, 1, SIG_VS, 1, "vsIdle");
    expectAt(18566, 1, SIG_X, 483, "preRstX");
    expectAt(18566, 1, SIG_Y, 11, "preRstY");

    // Colour requests: each step's result appears on the following cycle.
    foreach (steps[i]) begin
      waitRel(steps[i].k);
      applyStimulus(steps[i].bOn, steps[i].pOn, steps[i].bCol, steps[i].pCol);
      expectAt(steps[i].k + 1, 0, SIG_RGB, steps[i].expS, "rgb");
      expectAt(steps[i].k + 1, 1, SIG_RGB, steps[i].expD, "rgb");
    end

    // Mid-frame reset in the small raster's vsync/hsync/vblank region.
    waitRel(18566);
    checkOutput("S_eofRisesBeforeReset", sRises, 23);
    checkOutput("D_eofRisesBeforeReset", dRises, 0);
    reset = 1'b1;
    randomInputs();
    expectResetState(18567);
    expectResetState(18568);
    waitRel(18567);
    randomInputs();
    waitRel(18568);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    base = absCyc;

    expectAt(1, 0, SIG_TICK, 1, "resumeTick");
    expectAt(2, 0, SIG_X, 1, "resumeX");
    expectAt(37, 0, SIG_HS, 0, "resumeHs");
    expectAt(48, 0, SIG_X, 0, "resumeWrapX");
    expectAt(48, 0, SIG_Y, 1, "resumeWrapY");
    expectAt(479, 0, SIG_EOF, 0, "resumeEofLow");
    expectAt(480, 0, SIG_EOF, 1, "resumeEofRise");
    expectAt(480, 0, SIG_Y, 10, "resumeEofY");
    expectAt(2, 1, SIG_X, 1, "resumeX");
    expectAt(48, 1, SIG_X, 24, "resumeX24");
    expectAt(48, 1, SIG_Y, 0, "resumeY");

    waitRel(500);
    repeat (2) @(negedge clk);
    checkOutput("S_eofRisesTotal", sRises, 24);
    checkOutput("D_eofRisesTotal", dRises, 0);
    checkOutput("S_hsyncRunsSeen", int'(sHsRuns >= 100), 1);
    checkOutput("scoreboardLeftover", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
